// File: rtl/cl_axil_bram_ctrl.sv
// AXI4-Lite slave that maps register accesses onto a 2**BRAM_ADDR_WIDTH x DATA_WIDTH dual-port BRAM.
// Port A carries writes; port B carries reads and the pre-read of partial-strobe writes.
module cl_axil_bram_ctrl #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axil_araddr,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       bram_write_en_a,
  output logic                       bram_en_a,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0]      bram_write_data_a,
  output logic                       bram_write_en_b,
  output logic                       bram_en_b,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_b,
  output logic [DATA_WIDTH-1:0]      bram_write_data_b,
  input  logic [DATA_WIDTH-1:0]      bram_read_data_b
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_RMW_RD, W_RMW_WAIT, W_WRITE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

  w_state_t                   w_state_q, w_state_d;
  logic                       awready_q, awready_d;
  logic                       wready_q, wready_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [BRAM_ADDR_WIDTH-1:0] aw_idx_q, aw_idx_d;
  logic                       aw_oor_q, aw_oor_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      wstrb_q, wstrb_d;

  r_state_t                   r_state_q, r_state_d;
  logic                       arready_q, arready_d;
  logic                       rvalid_q, rvalid_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [BRAM_ADDR_WIDTH-1:0] ar_idx_q, ar_idx_d;

  logic                       last_grant_w_q, last_grant_w_d;

  logic                       aw_hs, w_hs, ar_hs;
  logic [BRAM_ADDR_WIDTH-1:0] aw_in_idx, ar_in_idx;
  logic                       aw_in_oor, ar_in_oor;
  logic                       req_r, req_w, grant_r, grant_w;
  logic                       unused_addr_bits;

  // Byte offset bits are dropped; anything above the word index is out of range.
  assign aw_in_idx = s_axil_awaddr[BRAM_ADDR_WIDTH+1:2];
  assign ar_in_idx = s_axil_araddr[BRAM_ADDR_WIDTH+1:2];
  assign aw_in_oor = |s_axil_awaddr[AXI_ADDR_WIDTH-1:BRAM_ADDR_WIDTH+2];
  assign ar_in_oor = |s_axil_araddr[AXI_ADDR_WIDTH-1:BRAM_ADDR_WIDTH+2];
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;
  assign ar_hs = s_axil_arvalid && arready_q;

  // Round-robin port B arbiter: on a tie the side not served last wins.
  always_comb begin
    req_r          = (r_state_q == R_REQ);
    req_w          = (w_state_q == W_RMW_RD);
    grant_r        = req_r && (!req_w || last_grant_w_q);
    grant_w        = req_w && !grant_r;
    last_grant_w_d = last_grant_w_q;
    if (grant_w) begin
      last_grant_w_d = 1'b1;
    end else if (grant_r) begin
      last_grant_w_d = 1'b0;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_idx_d  = aw_in_idx;
          aw_oor_d  = aw_in_oor;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
          wready_d = 1'b0;
        end
        if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
          if (aw_oor_d) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
          end else if (wstrb_d == '0) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
          end else if (&wstrb_d) begin
            w_state_d = W_WRITE;
          end else begin
            w_state_d = W_RMW_RD;
          end
        end
      end
      W_RMW_RD: begin
        if (grant_w) begin
          w_state_d = W_RMW_WAIT;
        end
      end
      W_RMW_WAIT: begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (!wstrb_q[i]) begin
            wdata_d[8*i +: 8] = bram_read_data_b[8*i +: 8];
          end
        end
        w_state_d = W_WRITE;
      end
      W_WRITE: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
        bresp_d   = RESP_OKAY;
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ar_idx_d  = ar_idx_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          arready_d = 1'b0;
          ar_idx_d  = ar_in_idx;
          if (ar_in_oor) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
            rresp_d   = RESP_SLVERR;
            rdata_d   = '0;
          end else begin
            r_state_d = R_REQ;
          end
        end
      end
      R_REQ: begin
        if (grant_r) begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        r_state_d = R_RESP;
        rvalid_d  = 1'b1;
        rresp_d   = RESP_OKAY;
        rdata_d   = bram_read_data_b;
      end
      R_RESP: begin
        if (s_axil_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q      <= W_IDLE;
      awready_q      <= 1'b1;
      wready_q       <= 1'b1;
      bvalid_q       <= 1'b0;
      bresp_q        <= RESP_OKAY;
      aw_idx_q       <= '0;
      aw_oor_q       <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      r_state_q      <= R_IDLE;
      arready_q      <= 1'b1;
      rvalid_q       <= 1'b0;
      rresp_q        <= RESP_OKAY;
      rdata_q        <= '0;
      ar_idx_q       <= '0;
      last_grant_w_q <= 1'b1;
    end else begin
      w_state_q      <= w_state_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      aw_idx_q       <= aw_idx_d;
      aw_oor_q       <= aw_oor_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      r_state_q      <= r_state_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rresp_q        <= rresp_d;
      rdata_q        <= rdata_d;
      ar_idx_q       <= ar_idx_d;
      last_grant_w_q <= last_grant_w_d;
    end
  end

  assign s_axil_awready    = awready_q;
  assign s_axil_wready     = wready_q;
  assign s_axil_bvalid     = bvalid_q;
  assign s_axil_bresp      = bresp_q;
  assign s_axil_arready    = arready_q;
  assign s_axil_rvalid     = rvalid_q;
  assign s_axil_rresp      = rresp_q;
  assign s_axil_rdata      = rdata_q;

  assign bram_en_a         = (w_state_q == W_WRITE);
  assign bram_write_en_a   = (w_state_q == W_WRITE);
  assign bram_addr_a       = aw_idx_q;
  assign bram_write_data_a = wdata_q;

  // Port B is driven in the grant cycle so read data lands one cycle later.
  assign bram_en_b         = grant_r || grant_w;
  assign bram_addr_b       = grant_r ? ar_idx_q : (grant_w ? aw_idx_q : '0);
  assign bram_write_en_b   = 1'b0;
  assign bram_write_data_b = '0;

endmodule

// File: tb/tb_cl_axil_bram_ctrl.sv
// Self-checking bench for cl_axil_bram_ctrl: directed vector table plus hand-written
// latency, handshake-ordering, arbitration and out-of-range sequences against a BRAM model.
module tb_cl_axil_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic        bram_write_en_a, bram_en_a;
  logic [7:0]  bram_addr_a;
  logic [31:0] bram_write_data_a;
  logic        bram_write_en_b, bram_en_b;
  logic [7:0]  bram_addr_b;
  logic [31:0] bram_write_data_b;
  logic [31:0] bram_read_data_b = '0;

  logic [31:0] mem [0:255] = '{default: '0};
  int          en_a_count = 0;
  int          en_b_count = 0;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  cl_axil_bram_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .s_axil_awaddr     (s_axil_awaddr),
    .s_axil_awvalid    (s_axil_awvalid),
    .s_axil_awready    (s_axil_awready),
    .s_axil_wdata      (s_axil_wdata),
    .s_axil_wstrb      (s_axil_wstrb),
    .s_axil_wvalid     (s_axil_wvalid),
    .s_axil_wready     (s_axil_wready),
    .s_axil_bresp      (s_axil_bresp),
    .s_axil_bvalid     (s_axil_bvalid),
    .s_axil_bready     (s_axil_bready),
    .s_axil_araddr     (s_axil_araddr),
    .s_axil_arvalid    (s_axil_arvalid),
    .s_axil_arready    (s_axil_arready),
    .s_axil_rdata      (s_axil_rdata),
    .s_axil_rresp      (s_axil_rresp),
    .s_axil_rvalid     (s_axil_rvalid),
    .s_axil_rready     (s_axil_rready),
    .bram_write_en_a   (bram_write_en_a),
    .bram_en_a         (bram_en_a),
    .bram_addr_a       (bram_addr_a),
    .bram_write_data_a (bram_write_data_a),
    .bram_write_en_b   (bram_write_en_b),
    .bram_en_b         (bram_en_b),
    .bram_addr_b       (bram_addr_b),
    .bram_write_data_b (bram_write_data_b),
    .bram_read_data_b  (bram_read_data_b)
  );

  // BRAM model: port A writes, port B registered read, plus enable counters.
  always @(posedge clk) begin
    if (bram_en_a && bram_write_en_a) mem[bram_addr_a] <= bram_write_data_a;
    if (bram_en_b) bram_read_data_b <= mem[bram_addr_b];
    if (bram_en_a) en_a_count <= en_a_count + 1;
    if (bram_en_b) en_b_count <= en_b_count + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
    s_axil_bready  = 1'b0;
    s_axil_rready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp, output bit timeout);
    int  n = 0;
    bit  aw_fire, w_fire;
    s_axil_awaddr  = a;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = d;
    s_axil_wstrb   = s;
    s_axil_wvalid  = 1'b1;
    s_axil_bready  = 1'b1;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 20) begin
      aw_fire = s_axil_awvalid && s_axil_awready;
      w_fire  = s_axil_wvalid && s_axil_wready;
      tick();
      n++;
      if (aw_fire) s_axil_awvalid = 1'b0;
      if (w_fire)  s_axil_wvalid  = 1'b0;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    while (!s_axil_bvalid && n < 20) begin
      tick();
      n++;
    end
    timeout = !s_axil_bvalid;
    resp = s_axil_bresp;
    tick();
    s_axil_bready = 1'b0;
  endtask

  task automatic doRead(input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp, output bit timeout);
    int n = 0;
    bit fire;
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b1;
    while (s_axil_arvalid && n < 20) begin
      fire = s_axil_arready;
      tick();
      n++;
      if (fire) s_axil_arvalid = 1'b0;
    end
    s_axil_arvalid = 1'b0;
    while (!s_axil_rvalid && n < 20) begin
      tick();
      n++;
    end
    timeout = !s_axil_rvalid;
    d    = s_axil_rdata;
    resp = s_axil_rresp;
    tick();
    s_axil_rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [1:0] resp,
                               output logic [31:0] rdata, output bit timeout);
    rdata = '0;
    if (v.is_write) doWrite(v.addr, v.data, v.strb, resp, timeout);
    else            doRead(v.addr, rdata, resp, timeout);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          timeout;
    int          a_before, b_before;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 2'b00, 32'hDEAD_BEAA};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0110, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 2'b00, 32'h11BB_CC44};
    vecs[5]  = '{1'b1, 32'h0000_0024, 32'h5566_7788, 4'b0000, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0024, 32'h0,         4'b0000, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_03FF, 32'h0,         4'b0000, 2'b00, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'b1000, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 2'b00, 32'h12FE_F00D};
    vecs[11] = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'b1111, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 2'b10, 32'h0};
    vecs[13] = '{1'b1, 32'h8000_0000, 32'h0123_4567, 4'b1111, 2'b10, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2'b00, 32'h0};

    // Reset values while rst is held.
    repeat (2) tick();
    checkOutput("rst awready", 32'(s_axil_awready), 32'd1);
    checkOutput("rst wready",  32'(s_axil_wready),  32'd1);
    checkOutput("rst arready", 32'(s_axil_arready), 32'd1);
    checkOutput("rst bvalid",  32'(s_axil_bvalid),  32'd0);
    checkOutput("rst rvalid",  32'(s_axil_rvalid),  32'd0);
    checkOutput("rst en_a",    32'(bram_en_a),      32'd0);
    checkOutput("rst en_b",    32'(bram_en_b),      32'd0);
    checkOutput("rst rdata",   s_axil_rdata,        32'd0);
    checkOutput("rst addr_a",  32'(bram_addr_a),    32'd0);
    checkOutput("rst wdata_a", bram_write_data_a,   32'd0);
    rst = 1'b0;
    tick();

    // Full-strobe write latency: handshakes in T, port A in T+1, bvalid in T+2.
    s_axil_awaddr = 32'h10; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    checkOutput("wr T+1 en_a",   32'(bram_en_a),       32'd1);
    checkOutput("wr T+1 we_a",   32'(bram_write_en_a), 32'd1);
    checkOutput("wr T+1 addr_a", 32'(bram_addr_a),     32'h04);
    checkOutput("wr T+1 data_a", bram_write_data_a,    32'hDEAD_BEEF);
    checkOutput("wr T+1 bvalid", 32'(s_axil_bvalid),   32'd0);
    tick();
    checkOutput("wr T+2 bvalid", 32'(s_axil_bvalid),   32'd1);
    checkOutput("wr T+2 bresp",  32'(s_axil_bresp),    32'd0);
    checkOutput("wr T+2 en_a",   32'(bram_en_a),       32'd0);
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    checkOutput("wr done bvalid",  32'(s_axil_bvalid),  32'd0);
    checkOutput("wr done awready", 32'(s_axil_awready), 32'd1);
    checkOutput("wr done wready",  32'(s_axil_wready),  32'd1);

    // Uncontended read latency: AR in T, en_b in T+1, rvalid in T+3.
    s_axil_araddr = 32'h10; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    checkOutput("rd T+1 en_b",    32'(bram_en_b),      32'd1);
    checkOutput("rd T+1 addr_b",  32'(bram_addr_b),    32'h04);
    checkOutput("rd T+1 arready", 32'(s_axil_arready), 32'd0);
    tick();
    checkOutput("rd T+2 en_b",    32'(bram_en_b),      32'd0);
    checkOutput("rd T+2 rvalid",  32'(s_axil_rvalid),  32'd0);
    tick();
    checkOutput("rd T+3 rvalid",  32'(s_axil_rvalid),  32'd1);
    checkOutput("rd T+3 rdata",   s_axil_rdata,        32'hDEAD_BEEF);
    checkOutput("rd T+3 rresp",   32'(s_axil_rresp),   32'd0);
    tick();
    s_axil_rready = 1'b0;
    checkOutput("rd done rvalid",  32'(s_axil_rvalid),  32'd0);
    checkOutput("rd done arready", 32'(s_axil_arready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], resp, rdata, timeout);
      checkOutput($sformatf("vec%0d timeout", i), 32'(timeout), 32'd0);
      checkOutput($sformatf("vec%0d resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      if (!vecs[i].is_write)
        checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
    end

    // W leads AW by three cycles, then bready is held low for five cycles.
    a_before = en_a_count;
    s_axil_wdata = 32'hA5A5_A5A5; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    checkOutput("wfirst wready",  32'(s_axil_wready),  32'd0);
    checkOutput("wfirst awready", 32'(s_axil_awready), 32'd1);
    checkOutput("wfirst en_a",    32'(bram_en_a),      32'd0);
    tick();
    tick();
    s_axil_awaddr = 32'h40; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    checkOutput("wfirst write en_a",   32'(bram_en_a),    32'd1);
    checkOutput("wfirst write addr_a", 32'(bram_addr_a),  32'h10);
    checkOutput("wfirst write data_a", bram_write_data_a, 32'hA5A5_A5A5);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bstall%0d bvalid", k),  32'(s_axil_bvalid),  32'd1);
      checkOutput($sformatf("bstall%0d bresp", k),   32'(s_axil_bresp),   32'd0);
      checkOutput($sformatf("bstall%0d awready", k), 32'(s_axil_awready), 32'd0);
      checkOutput($sformatf("bstall%0d wready", k),  32'(s_axil_wready),  32'd0);
      tick();
    end
    s_axil_bready = 1'b1;
    checkOutput("bstall last bvalid", 32'(s_axil_bvalid), 32'd1);
    tick();
    s_axil_bready = 1'b0;
    checkOutput("bstall done bvalid",  32'(s_axil_bvalid),  32'd0);
    checkOutput("bstall done awready", 32'(s_axil_awready), 32'd1);
    checkOutput("bstall done wready",  32'(s_axil_wready),  32'd1);
    checkOutput("wfirst single write", 32'(en_a_count - a_before), 32'd1);
    doRead(32'h40, rdata, resp, timeout);
    checkOutput("wfirst readback", rdata, 32'hA5A5_A5A5);

    // Out-of-range accesses must not touch the BRAM.
    a_before = en_a_count;
    b_before = en_b_count;
    doRead(32'h400, rdata, resp, timeout);
    checkOutput("oor rd resp",  32'(resp), 32'd2);
    checkOutput("oor rd rdata", rdata,     32'd0);
    doWrite(32'h800, 32'hFFFF_FFFF, 4'hF, resp, timeout);
    checkOutput("oor wr resp",  32'(resp), 32'd2);
    checkOutput("oor en_a count", 32'(en_a_count - a_before), 32'd0);
    checkOutput("oor en_b count", 32'(en_b_count - b_before), 32'd0);

    // Port B contention straight after reset: read wins, write pre-read follows.
    doWrite(32'h30, 32'h0102_0304, 4'hF, resp, timeout);
    doReset();
    s_axil_awaddr = 32'h30; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h0000_EE00; s_axil_wstrb = 4'b0010; s_axil_wvalid = 1'b1;
    s_axil_araddr = 32'h20; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    checkOutput("arb T+1 en_b",   32'(bram_en_b),   32'd1);
    checkOutput("arb T+1 addr_b", 32'(bram_addr_b), 32'h08);
    tick();
    checkOutput("arb T+2 en_b",   32'(bram_en_b),   32'd1);
    checkOutput("arb T+2 addr_b", 32'(bram_addr_b), 32'h0C);
    tick();
    checkOutput("arb T+3 rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("arb T+3 rdata",  s_axil_rdata,       32'h11BB_CC44);
    checkOutput("arb T+3 en_a",   32'(bram_en_a),     32'd0);
    tick();
    s_axil_rready = 1'b0;
    checkOutput("arb T+4 en_a",   32'(bram_en_a),     32'd1);
    checkOutput("arb T+4 addr_a", 32'(bram_addr_a),   32'h0C);
    checkOutput("arb T+4 data_a", bram_write_data_a,  32'h0102_EE04);
    checkOutput("arb T+4 rvalid", 32'(s_axil_rvalid), 32'd0);
    tick();
    checkOutput("arb T+5 bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("arb T+5 bresp",  32'(s_axil_bresp),  32'd0);
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
    doRead(32'h30, rdata, resp, timeout);
    checkOutput("arb readback timeout", 32'(timeout), 32'd0);
    checkOutput("arb readback", rdata, 32'h0102_EE04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_axil_bram_ctrl.md
Name: cl_axil_bram_ctrl

Overview:
- AXI4-Lite slave that turns register-space accesses into 256x32 dual-port BRAM accesses.
- Sits directly upstream of the BRAM wrapper. Writes go out on BRAM port A; reads and read-modify-write (RMW) pre-reads go out on port B.
- Supports one outstanding write and one outstanding read at a time.
- Partial byte strobes are handled with RMW because the BRAM has no byte enables.

Parameters:
- AXI_ADDR_WIDTH, 32, byte-address width of the AXI-Lite slave port.
- BRAM_ADDR_WIDTH, 8, BRAM word-address width; depth = 2**BRAM_ADDR_WIDTH.
- DATA_WIDTH, 32, AXI and BRAM data width; strobe width = DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axil_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axil_awvalid  in  1  write address valid. / s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  DATA_WIDTH  write data. / s_axil_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_axil_wvalid  in  1  write data valid. / s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  write response. / s_axil_bvalid  out  1  response valid. / s_axil_bready  in  1  response ready.
- s_axil_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axil_arvalid  in  1  read address valid. / s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  DATA_WIDTH  read data. / s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid. / s_axil_rready  in  1  read data ready.
- bram_write_en_a  out  1  port A write enable. / bram_en_a  out  1  port A enable.
- bram_addr_a  out  BRAM_ADDR_WIDTH  port A word address. / bram_write_data_a  out  DATA_WIDTH  port A write data.
- bram_write_en_b  out  1  port B write enable, tied 0.
- bram_en_b  out  1  port B enable. / bram_addr_b  out  BRAM_ADDR_WIDTH  port B word address.
- bram_write_data_b  out  DATA_WIDTH  port B write data, tied 0.
- bram_read_data_b  in  DATA_WIDTH  port B read data, valid the cycle after bram_en_b.

Behaviour:
- Reset:
  - Clock is clk; reset rst is asynchronous and active-high.
  - Both FSMs go to IDLE.
  - All valid and enable outputs are 0.
  - awready, wready and arready are 1.
  - bresp, rresp, rdata and all BRAM address/data outputs are 0.
  - Arbiter last-grant is set to write, so the first tie goes to read.
- Address decode:
  - Word index = addr[BRAM_ADDR_WIDTH+1:2]; addr[1:0] is ignored.
  - Any nonzero bit above BRAM_ADDR_WIDTH+1 is out-of-range.
  - Out-of-range accesses make no BRAM access and return SLVERR (2'b10). Out-of-range reads return rdata 0.
- Write FSM states: W_IDLE, W_RMW_RD, W_RMW_WAIT, W_WRITE, W_RESP.
  - W_IDLE: awready and wready are deasserted individually once their beat is captured; AW and W may arrive in either order or together.
  - When both beats are held, the next state is chosen as follows:
    - out-of-range: W_RESP with SLVERR.
    - wstrb == 0: W_RESP with OKAY, no BRAM access.
    - wstrb all ones: W_WRITE.
    - otherwise: W_RMW_RD.
  - W_RMW_RD: request port B; on grant, drive bram_en_b and the address, then go to W_RMW_WAIT.
  - W_RMW_WAIT: merge bram_read_data_b with wdata per byte strobe, then go to W_WRITE.
  - W_WRITE: assert bram_en_a and bram_write_en_a for exactly one cycle, then go to W_RESP with OKAY.
  - W_RESP: hold bvalid until bready. After the handshake go to W_IDLE and reassert awready and wready.
  - Full-strobe latency: both handshakes in cycle T, port A write in T+1, bvalid from T+2.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: arready = 1; the AR handshake captures the address. Out-of-range goes to R_RESP with SLVERR and rdata 0.
  - R_REQ: request port B; on grant, drive bram_en_b and the address, then go to R_WAIT.
  - R_WAIT: register bram_read_data_b into rdata, set rresp OKAY, then go to R_RESP.
  - R_RESP: hold rvalid, rdata and rresp stable until rready, then go to R_IDLE.
  - Uncontended latency: AR handshake in T, en_b in T+1, rvalid from T+3.
- Port B arbiter:
  - Serves the R_REQ and W_RMW_RD requests.
  - A lone request is granted the same cycle.
  - Simultaneous requests are granted to the requester not granted last (round-robin). The loser waits one cycle.
- No ordering between the read and write channels. A read to an address being written may return old or new data.
- Reset mid-transaction aborts it: any pending response is dropped and a half-merged write is discarded.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x010 with wstrb F, AW and W in the same cycle -> port A writes addr 0x04 in T+1; bvalid in T+2 with OKAY.
- Read 0x010 with rready held high -> bram_en_b addr 0x04 in T+1; rvalid in T+3 with rdata 0xDEADBEEF and rresp OKAY.
- Write 0x000000AA with wstrb 0001 to 0x010 -> port B read, then port A write of 0xDEADBEAA; a later read returns 0xDEADBEAA.
- W arrives 3 cycles before AW, and bready is held low for 5 cycles -> single write; bvalid stays stable; awready/wready stay low until the B handshake.
- Partial-strobe write and read to different addresses contend for port B in the same cycle -> read is granted first (reset last-grant = write), the write pre-read follows one cycle later; both complete correctly.
- Read 0x400 and write 0x800 (out-of-range) -> no BRAM enables; SLVERR on both channels; rdata 0.
